// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: DEPTH-entry byte FIFO drained into a UART_TX by a launch FSM.
// Optional overflow reporting (ovf / ovf_clr) is built when UART_TX_FEEDER_OVF_EN is defined.
module uart_tx_feeder #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     wr_en,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DATA_WIDTH-1:0]    tx_p_data,
  output logic                     tx_data_valid,
  input  logic                     tx_busy
`ifdef UART_TX_FEEDER_OVF_EN
  ,
  input  logic                     ovf_clr,
  output logic                     ovf
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  launch;
  logic                  push;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A write is accepted only when there is room; a pop on the same edge does not rescue it.
  assign push      = wr_en && !full;
  assign level_nxt = level + LVL_W'(push) - LVL_W'(launch);

  // Launch FSM: pick the next state, timeout count and launch decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT_BUSY;
          cnt_nxt   = '0;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // UART never acknowledged; the byte is treated as consumed.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FIFO pointers, occupancy flags and UART-facing outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      level         <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      tx_p_data     <= '0;
      tx_data_valid <= 1'b0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (launch) rd_ptr <= rd_ptr + PTR_W'(1);
      level         <= level_nxt;
      full          <= (level_nxt == LVL_W'(DEPTH));
      empty         <= (level_nxt == '0);
      tx_data_valid <= launch;
      if (launch) tx_p_data <= mem[rd_ptr];
    end
  end

  // FIFO storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_FEEDER_OVF_EN
  // Sticky overflow flag; a drop on the clearing edge wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed timing and data expectations.
module tb_uart_tx_feeder;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TO    = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic          full, empty;
  logic [LW-1:0] level;
  logic [DW-1:0] tx_p_data;
  logic          tx_data_valid;
  logic          tx_busy;
  logic          force_busy = 1'b0;
  int            resp_cnt = 0;
  int            busy_len = 0;
`ifdef UART_TX_FEEDER_OVF_EN
  logic          ovf_clr = 1'b0;
  logic          ovf;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en),
    .full(full), .empty(empty), .level(level),
    .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid), .tx_busy(tx_busy)
`ifdef UART_TX_FEEDER_OVF_EN
    , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART stand-in: busy for busy_len cycles after it sees a strobe (busy_len=0: never busy).
  assign tx_busy = force_busy | (resp_cnt != 0);
  always @(posedge clk) begin
    if (tx_data_valid && busy_len > 0) resp_cnt <= busy_len;
    else if (resp_cnt > 0)             resp_cnt <= resp_cnt - 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus "where is the transmitter in its handshake".
  logic [DW-1:0] mq[$];
  int            m_phase = 0;   // 0 ready, 1 awaiting busy, 2 frame in progress
  int            m_waited = 0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          m_ovf = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_phase = 0; m_waited = 0; m_valid = 1'b0; m_data = '0; m_ovf = 1'b0;
    end else begin
      bit was_full, go;
      was_full = (mq.size() == DEPTH);
      go = (m_phase == 0) && (mq.size() != 0) && !tx_busy;
      if (go) begin
        m_data   = mq.pop_front();
        m_phase  = 1;
        m_waited = 0;
      end else if (m_phase == 1) begin
        m_waited++;
        if (tx_busy)             m_phase = 2;
        else if (m_waited == TO) m_phase = 0;
      end else if (m_phase == 2 && !tx_busy) begin
        m_phase = 0;
      end
      m_valid = go;
      if (wr_en && !was_full) mq.push_back(wr_data);
`ifdef UART_TX_FEEDER_OVF_EN
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (ovf_clr)      m_ovf = 1'b0;
`endif
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("level", 32'(level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("tx_data_valid", 32'(tx_data_valid), 32'(m_valid));
    chk("tx_p_data", 32'(tx_p_data), 32'(m_data));
`ifdef UART_TX_FEEDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
  end

  // Strobe collector.
  logic [DW-1:0] rx_q[$];
  int            rx_t[$];
  always @(negedge clk) begin
    if (tx_data_valid) begin
      rx_q.push_back(tx_p_data);
      rx_t.push_back(cyc);
    end
  end

  task automatic push(input logic [DW-1:0] b);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int bound);
    for (int k = 0; k < bound && rx_q.size() < n; k++) @(negedge clk);
  endtask

  task automatic clear_rx();
    rx_q.delete(); rx_t.delete();
  endtask

  logic [DW-1:0] sent[$];

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_valid", 32'(tx_data_valid), 0);
    chk("rst_data", 32'(tx_p_data), 0);

    // Single byte latency; no busy response so it times out afterwards.
    busy_len = 0;
    push(8'hA5);
    chk("a5_level_after_push", 32'(level), 1);
    chk("a5_valid_early", 32'(tx_data_valid), 0);
    @(negedge clk);
    chk("a5_valid", 32'(tx_data_valid), 1);
    chk("a5_data", 32'(tx_p_data), 32'hA5);
    chk("a5_level", 32'(level), 0);
    @(negedge clk);
    chk("a5_one_cycle", 32'(tx_data_valid), 0);
    repeat (8) @(negedge clk);

    // Three bytes, each frame busy for 10 cycles.
    busy_len = 10;
    clear_rx();
    push(8'h11); push(8'h22); push(8'h33);
    wait_rx(3, 200);
    chk("seq_count", 32'(rx_q.size()), 3);
    if (rx_q.size() == 3) begin
      chk("seq_b0", 32'(rx_q[0]), 32'h11);
      chk("seq_b1", 32'(rx_q[1]), 32'h22);
      chk("seq_b2", 32'(rx_q[2]), 32'h33);
      chk("seq_gap01", 32'(rx_t[1] - rx_t[0]), 13);
      chk("seq_gap12", 32'(rx_t[2] - rx_t[1]), 13);
    end
    repeat (20) @(negedge clk);

    // Fill under held busy; 9th byte dropped.
    busy_len = 0;
    force_busy = 1'b1;
    for (int i = 0; i < 9; i++) push(8'(8'h80 + i));
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 8);
`ifdef UART_TX_FEEDER_OVF_EN
    chk("fill_ovf", 32'(ovf), 1);
    repeat (2) @(negedge clk);
    chk("ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hEF;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_drop_wins", 32'(ovf), 1);
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", 32'(ovf), 0);
`endif
    // Release busy while writing into the still-full FIFO on the launch edge.
    clear_rx();
    force_busy = 1'b0; busy_len = 3;
    wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    chk("drop_on_pop_level", 32'(level), 7);
    chk("drop_on_pop_valid", 32'(tx_data_valid), 1);
    chk("drop_on_pop_data", 32'(tx_p_data), 32'h80);
    wait_rx(8, 400);
    chk("fill_drain_count", 32'(rx_q.size()), 8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++)
      chk("fill_drain_byte", 32'(rx_q[i]), 32'(8'h80 + i));
    repeat (20) @(negedge clk);

    // Busy never rises: timeout after 4 cycles, then next byte launches.
    busy_len = 0;
    clear_rx();
    push(8'h5A); push(8'h6B);
    wait_rx(2, 100);
    chk("to_count", 32'(rx_q.size()), 2);
    if (rx_q.size() == 2) begin
      chk("to_b0", 32'(rx_q[0]), 32'h5A);
      chk("to_b1", 32'(rx_q[1]), 32'h6B);
      chk("to_gap", 32'(rx_t[1] - rx_t[0]), 5);
    end
    repeat (10) @(negedge clk);

    // Reset in the middle of a frame with three bytes queued.
    busy_len = 20;
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    @(negedge clk);
    chk("midrst_level_before", 32'(level), 3);
    chk("midrst_busy_before", 32'(tx_busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_level", 32'(level), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_valid", 32'(tx_data_valid), 0);
    @(negedge clk);
    rst = 1'b1;
    clear_rx();
    repeat (40) @(negedge clk);
    chk("midrst_no_strobe", 32'(rx_q.size()), 0);
    push(8'hD7);
    wait_rx(1, 50);
    chk("midrst_new_count", 32'(rx_q.size()), 1);
    if (rx_q.size() == 1) chk("midrst_new_byte", 32'(rx_q[0]), 32'hD7);
    repeat (30) @(negedge clk);

    // 20 bytes with flow control while draining: pointers wrap, no loss.
    busy_len = 2;
    clear_rx();
    sent.delete();
    begin
      int i = 0;
      int guard = 0;
      while (i < 20 && guard < 1000) begin
        if (mq.size() < DEPTH) begin
          wr_en = 1'b1; wr_data = 8'(i * 7 + 3);
          sent.push_back(8'(i * 7 + 3));
          i++;
        end else begin
          wr_en = 1'b0;
        end
        @(negedge clk);
        guard++;
      end
      wr_en = 1'b0;
    end
    wait_rx(20, 1000);
    chk("wrap_count", 32'(rx_q.size()), 20);
    for (int i = 0; i < 20 && i < rx_q.size(); i++)
      chk("wrap_byte", 32'(rx_q[i]), 32'(sent[i]));
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
